// File: rtl/counter_cmd_sequencer_if.sv
// Command and completion handshakes between a requester and counter_cmd_sequencer.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
// the sender holds its payload stable while valid is high and not yet accepted.
interface counter_cmd_sequencer_if #(
   parameter int OVF_CNT_W = 8
);
   logic                 cmd_valid_in;
   logic                 cmd_ready_out;
   logic [1:0]           cmd_op_in;
   logic [7:0]           cmd_arg_in;
   logic                 done_valid_out;
   logic                 done_ready_in;
   logic [7:0]           done_value_out;
   logic [OVF_CNT_W-1:0] done_ovf_cnt_out;
   logic                 done_aborted_out;

   modport master (
      output cmd_valid_in, cmd_op_in, cmd_arg_in, done_ready_in,
      input  cmd_ready_out, done_valid_out, done_value_out, done_ovf_cnt_out, done_aborted_out
   );

   modport slave (
      input  cmd_valid_in, cmd_op_in, cmd_arg_in, done_ready_in,
      output cmd_ready_out, done_valid_out, done_value_out, done_ovf_cnt_out, done_aborted_out
   );
endinterface

// File: rtl/counter_cmd_sequencer.sv
// Queued command sequencer driving an 8-bit up/down counter's en/set/up controls
// and returning one completion record (final count, wrap count, aborted) per command.
module counter_cmd_sequencer #(
   parameter int CMD_Q_DEPTH = 4,
   parameter int OVF_CNT_W   = 8
) (
   input  logic                  clk_in,
   input  logic                  nrst_in,
   counter_cmd_sequencer_if.slave cmd_if,
   input  logic                  abort_in,
   output logic                  en_ctrl_out,
   output logic                  set_ctrl_out,
   output logic                  up_ctrl_out,
   output logic [7:0]            counter_val_out,
   input  logic [7:0]            counter_q_in,
   input  logic                  ovf_in,
   output logic                  busy_out,
   output logic [2:0]            state_dbg_out
);

   localparam int AW = $clog2(CMD_Q_DEPTH);
   localparam logic [AW:0]          PTR_ONE = 1;
   localparam logic [OVF_CNT_W-1:0] OVF_ONE = 1;
   localparam logic [OVF_CNT_W-1:0] OVF_MAX = '1;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_UP    = 2'b01;
   localparam logic [1:0] OP_DOWN  = 2'b10;
   localparam logic [1:0] OP_PAUSE = 2'b11;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      EXEC_LOAD  = 3'd1,
      EXEC_RUN   = 3'd2,
      EXEC_PAUSE = 3'd3,
      REPORT     = 3'd4
   } state_t;

   state_t state;

   logic [1:0]    q_op  [CMD_Q_DEPTH];
   logic [7:0]    q_arg [CMD_Q_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic          q_empty, q_full, push, pop;
   logic [1:0]    head_op;
   logic [7:0]    head_arg;

   logic [7:0]           rem;
   logic [OVF_CNT_W-1:0] ovf_cnt;
   logic                 aborted;

   assign q_empty  = (wr_ptr == rd_ptr);
   assign q_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head_op  = q_op[rd_ptr[AW-1:0]];
   assign head_arg = q_arg[rd_ptr[AW-1:0]];

   // Ready is gated by reset so nothing is accepted while the block is held in reset.
   assign cmd_if.cmd_ready_out = nrst_in && !q_full && !abort_in;
   assign push = cmd_if.cmd_valid_in && cmd_if.cmd_ready_out;
   assign pop  = (state == IDLE) && !q_empty && !abort_in;

   assign busy_out      = (state != IDLE) || !q_empty;
   assign state_dbg_out = state;

   always_ff @(posedge clk_in) begin
      if (push) begin
         q_op[wr_ptr[AW-1:0]]  <= cmd_if.cmd_op_in;
         q_arg[wr_ptr[AW-1:0]] <= cmd_if.cmd_arg_in;
      end
   end

   // Abort flushes by catching the read pointer up; no push can coincide with it.
   always_ff @(posedge clk_in or negedge nrst_in) begin
      if (!nrst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (abort_in) rd_ptr <= wr_ptr;
         else if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk_in or negedge nrst_in) begin
      if (!nrst_in) begin
         state                   <= IDLE;
         en_ctrl_out             <= 1'b0;
         set_ctrl_out            <= 1'b0;
         up_ctrl_out             <= 1'b0;
         counter_val_out         <= 8'd0;
         rem                     <= 8'd0;
         ovf_cnt                 <= '0;
         aborted                 <= 1'b0;
         cmd_if.done_valid_out   <= 1'b0;
         cmd_if.done_value_out   <= 8'd0;
         cmd_if.done_ovf_cnt_out <= '0;
         cmd_if.done_aborted_out <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pop) begin
                  rem     <= head_arg;
                  ovf_cnt <= '0;
                  aborted <= 1'b0;
                  unique case (head_op)
                     OP_LOAD: begin
                        set_ctrl_out    <= 1'b1;
                        counter_val_out <= head_arg;
                        state           <= EXEC_LOAD;
                     end
                     OP_UP, OP_DOWN: begin
                        if (head_arg == 8'd0) begin
                           state <= REPORT;
                        end else begin
                           en_ctrl_out <= 1'b1;
                           up_ctrl_out <= (head_op == OP_UP);
                           state       <= EXEC_RUN;
                        end
                     end
                     OP_PAUSE: state <= (head_arg == 8'd0) ? REPORT : EXEC_PAUSE;
                  endcase
               end
            end
            EXEC_LOAD: begin
               set_ctrl_out <= 1'b0;
               aborted      <= abort_in;
               state        <= REPORT;
            end
            EXEC_RUN: begin
               // en is high for every cycle spent here, so each cycle is one counter step.
               rem <= rem - 8'd1;
               if (ovf_in && ovf_cnt != OVF_MAX) ovf_cnt <= ovf_cnt + OVF_ONE;
               if (abort_in || rem == 8'd1) begin
                  en_ctrl_out <= 1'b0;
                  aborted     <= abort_in;
                  state       <= REPORT;
               end
            end
            EXEC_PAUSE: begin
               rem <= rem - 8'd1;
               if (abort_in || rem == 8'd1) begin
                  aborted <= abort_in;
                  state   <= REPORT;
               end
            end
            REPORT: begin
               // First cycle captures the count after the final counter update has landed.
               if (!cmd_if.done_valid_out) begin
                  cmd_if.done_valid_out   <= 1'b1;
                  cmd_if.done_value_out   <= counter_q_in;
                  cmd_if.done_ovf_cnt_out <= ovf_cnt;
                  cmd_if.done_aborted_out <= aborted;
               end else if (cmd_if.done_ready_in) begin
                  cmd_if.done_valid_out <= 1'b0;
                  state                 <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Directed bench for counter_cmd_sequencer with a behavioural 8-bit up/down counter
// attached to its control outputs.
module tb_counter_cmd_sequencer;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_UP    = 2'b01;
   localparam logic [1:0] OP_DOWN  = 2'b10;
   localparam logic [1:0] OP_PAUSE = 2'b11;

   logic       clk;
   logic       nrst;
   logic       abort;
   logic       en_ctrl, set_ctrl, up_ctrl;
   logic [7:0] counter_val;
   logic [7:0] cnt_q;
   logic       ovf;
   logic       busy;
   logic [2:0] state_dbg;

   int n_checks = 0;
   int n_fail   = 0;
   int en_cycles = 0;
   int set_cycles = 0;
   int overlap = 0;

   counter_cmd_sequencer_if #(.OVF_CNT_W(8)) cmd_if ();

   counter_cmd_sequencer #(.CMD_Q_DEPTH(4), .OVF_CNT_W(8)) dut (
      .clk_in          (clk),
      .nrst_in         (nrst),
      .cmd_if          (cmd_if),
      .abort_in        (abort),
      .en_ctrl_out     (en_ctrl),
      .set_ctrl_out    (set_ctrl),
      .up_ctrl_out     (up_ctrl),
      .counter_val_out (counter_val),
      .counter_q_in    (cnt_q),
      .ovf_in          (ovf),
      .busy_out        (busy),
      .state_dbg_out   (state_dbg)
   );

   // Clock and reset-aware counter model
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge nrst) begin
      if (!nrst) cnt_q <= 8'd0;
      else if (set_ctrl) cnt_q <= counter_val;
      else if (en_ctrl) cnt_q <= up_ctrl ? cnt_q + 8'd1 : cnt_q - 8'd1;
   end
   assign ovf = en_ctrl && (up_ctrl ? (cnt_q == 8'hFF) : (cnt_q == 8'h00));

   always @(posedge clk) begin
      if (nrst) begin
         if (en_ctrl) en_cycles = en_cycles + 1;
         if (set_ctrl) set_cycles = set_cycles + 1;
         if (en_ctrl && set_ctrl) overlap = overlap + 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Driver: offer one command and hold it until accepted.
   task automatic push(input logic [1:0] op, input logic [7:0] arg);
      int b;
      b = 0;
      cmd_if.cmd_valid_in = 1'b1;
      cmd_if.cmd_op_in    = op;
      cmd_if.cmd_arg_in   = arg;
      while (!cmd_if.cmd_ready_out && b < 300) begin
         @(negedge clk);
         b++;
      end
      if (b >= 300) check("push_timeout", 32'(cmd_if.cmd_ready_out), 32'd1);
      @(posedge clk);
      #1;
      cmd_if.cmd_valid_in = 1'b0;
   endtask

   // Scoreboard side: wait for a record, compare it, then consume it.
   task automatic wait_done(input string name, input logic [7:0] exp_val,
                            input logic [7:0] exp_ovf, input logic exp_ab);
      int b;
      b = 0;
      while (!cmd_if.done_valid_out && b < 500) begin
         @(negedge clk);
         b++;
      end
      check({name, "_valid"}, 32'(cmd_if.done_valid_out), 32'd1);
      check({name, "_value"}, 32'(cmd_if.done_value_out), 32'(exp_val));
      check({name, "_ovf"}, 32'(cmd_if.done_ovf_cnt_out), 32'(exp_ovf));
      check({name, "_aborted"}, 32'(cmd_if.done_aborted_out), 32'(exp_ab));
      cmd_if.done_ready_in = 1'b1;
      @(posedge clk);
      #1;
      cmd_if.done_ready_in = 1'b0;
   endtask

   typedef struct {
      logic [1:0] op;
      logic [7:0] arg;
      logic [7:0] exp_val;
      logic [7:0] exp_ovf;
      int         exp_en;
      int         exp_set;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int e0, s0, b;

      vecs[0]  = '{OP_LOAD,  8'h10, 8'h10, 8'd0, 0, 1};
      vecs[1]  = '{OP_UP,    8'd3,  8'h13, 8'd0, 3, 0};
      vecs[2]  = '{OP_LOAD,  8'hFE, 8'hFE, 8'd0, 0, 1};
      vecs[3]  = '{OP_UP,    8'd4,  8'h02, 8'd1, 4, 0};
      vecs[4]  = '{OP_LOAD,  8'h01, 8'h01, 8'd0, 0, 1};
      vecs[5]  = '{OP_DOWN,  8'd3,  8'hFE, 8'd1, 3, 0};
      vecs[6]  = '{OP_UP,    8'd0,  8'hFE, 8'd0, 0, 0};
      vecs[7]  = '{OP_PAUSE, 8'd0,  8'hFE, 8'd0, 0, 0};
      vecs[8]  = '{OP_PAUSE, 8'd3,  8'hFE, 8'd0, 0, 0};
      vecs[9]  = '{OP_LOAD,  8'h00, 8'h00, 8'd0, 0, 1};
      vecs[10] = '{OP_DOWN,  8'd2,  8'hFE, 8'd1, 2, 0};
      vecs[11] = '{OP_UP,    8'd1,  8'hFF, 8'd0, 1, 0};

      nrst = 1'b0;
      abort = 1'b0;
      cmd_if.cmd_valid_in  = 1'b0;
      cmd_if.cmd_op_in     = 2'b00;
      cmd_if.cmd_arg_in    = 8'd0;
      cmd_if.done_ready_in = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_en", 32'(en_ctrl), 32'd0);
      check("rst_set", 32'(set_ctrl), 32'd0);
      check("rst_up", 32'(up_ctrl), 32'd0);
      check("rst_val", 32'(counter_val), 32'd0);
      check("rst_done_valid", 32'(cmd_if.done_valid_out), 32'd0);
      check("rst_done_value", 32'(cmd_if.done_value_out), 32'd0);
      check("rst_done_ovf", 32'(cmd_if.done_ovf_cnt_out), 32'd0);
      check("rst_done_aborted", 32'(cmd_if.done_aborted_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(cmd_if.cmd_ready_out), 32'd0);
      check("rst_state", 32'(state_dbg), 32'd0);
      nrst = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_ready", 32'(cmd_if.cmd_ready_out), 32'd1);

      // Table-driven single commands
      for (int i = 0; i < 12; i++) begin
         e0 = en_cycles;
         s0 = set_cycles;
         push(vecs[i].op, vecs[i].arg);
         wait_done($sformatf("vec%0d", i), vecs[i].exp_val, vecs[i].exp_ovf, 1'b0);
         check($sformatf("vec%0d_en_cycles", i), 32'(en_cycles - e0), 32'(vecs[i].exp_en));
         check($sformatf("vec%0d_set_cycles", i), 32'(set_cycles - s0), 32'(vecs[i].exp_set));
      end

      // Fill the queue while the first record is held back
      push(OP_LOAD, 8'h20);
      push(OP_UP, 8'd1);
      push(OP_UP, 8'd1);
      push(OP_DOWN, 8'd2);
      push(OP_LOAD, 8'h55);
      check("fill_ready_low", 32'(cmd_if.cmd_ready_out), 32'd0);
      check("fill_busy", 32'(busy), 32'd1);
      repeat (5) @(negedge clk);
      check("fill_hold_valid_a", 32'(cmd_if.done_valid_out), 32'd1);
      check("fill_hold_value_a", 32'(cmd_if.done_value_out), 32'h20);
      repeat (3) @(negedge clk);
      check("fill_hold_valid_b", 32'(cmd_if.done_valid_out), 32'd1);
      check("fill_hold_value_b", 32'(cmd_if.done_value_out), 32'h20);
      check("fill_still_full", 32'(cmd_if.cmd_ready_out), 32'd0);
      wait_done("fill0", 8'h20, 8'd0, 1'b0);
      wait_done("fill1", 8'h21, 8'd0, 1'b0);
      wait_done("fill2", 8'h22, 8'd0, 1'b0);
      wait_done("fill3", 8'h20, 8'd0, 1'b0);
      wait_done("fill4", 8'h55, 8'd0, 1'b0);
      check("fill_idle_busy", 32'(busy), 32'd0);

      // Abort in idle refuses any offered push
      abort = 1'b1;
      #1;
      check("abort_idle_ready", 32'(cmd_if.cmd_ready_out), 32'd0);
      @(posedge clk);
      #1;
      abort = 1'b0;

      // Abort ten enable cycles into an UP 100 with two commands queued behind it
      push(OP_LOAD, 8'h30);
      wait_done("abort_pre", 8'h30, 8'd0, 1'b0);
      e0 = en_cycles;
      push(OP_UP, 8'd100);
      push(OP_DOWN, 8'd5);
      push(OP_LOAD, 8'd7);
      b = 0;
      while ((en_cycles - e0) < 10 && b < 200) begin
         @(negedge clk);
         b++;
      end
      check("abort_reach_10", 32'(b < 200), 32'd1);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort_en_low", 32'(en_ctrl), 32'd0);
      wait_done("abort_rec", 8'h3B, 8'd0, 1'b1);
      check("abort_en_cycles", 32'(en_cycles - e0), 32'd11);
      check("abort_busy", 32'(busy), 32'd0);
      e0 = en_cycles;
      s0 = set_cycles;
      repeat (20) @(negedge clk);
      check("abort_no_more_rec", 32'(cmd_if.done_valid_out), 32'd0);
      check("abort_no_more_en", 32'(en_cycles - e0), 32'd0);
      check("abort_no_more_set", 32'(set_cycles - s0), 32'd0);

      // Reset in the middle of an UP 200
      push(OP_UP, 8'd200);
      repeat (10) @(negedge clk);
      check("rstmid_en_before", 32'(en_ctrl), 32'd1);
      #2;
      nrst = 1'b0;
      #1;
      check("rstmid_en", 32'(en_ctrl), 32'd0);
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_done", 32'(cmd_if.done_valid_out), 32'd0);
      check("rstmid_ready", 32'(cmd_if.cmd_ready_out), 32'd0);
      @(negedge clk);
      nrst = 1'b1;
      e0 = en_cycles;
      repeat (20) @(negedge clk);
      check("rstmid_after_done", 32'(cmd_if.done_valid_out), 32'd0);
      check("rstmid_after_busy", 32'(busy), 32'd0);
      check("rstmid_after_en", 32'(en_cycles - e0), 32'd0);
      check("rstmid_after_state", 32'(state_dbg), 32'd0);

      check("set_en_overlap", 32'(overlap), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
